fetch_unit: RTL and testbench

- Instruction-fetch producer that drives the IF/ID pipeline register with `(pc, instruction)` pairs.
- Owns the program counter and issues one outstanding read at a time on a request/response instruction-memory port.
- Honours hazard freeze and branch redirect. Discards any in-flight fetch that a redirect has made stale.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/fetch_pc_reg.sv | 31 +++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Types and constants shared by the fetch unit and its program-counter register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_KILL = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_STEP_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load (redirect) beats increment (emit), otherwise hold.
module fetch_pc_reg #(
  parameter int unsigned           PC_WIDTH = 32,
  parameter int unsigned           PC_STEP  = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_value,
  input  logic                incr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_seq
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  // Sum truncates to PC_WIDTH, so the top of the address space wraps to zero.
  assign pc_seq = pc + STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (incr) begin
      pc <= pc_seq;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, freeze buffering and redirect kill.
//
// state | meaning
// REQ   | request pc_reg on imem, waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid
// HOLD  | data returned under freeze, held in buffer until freeze drops
// KILL  | redirected while a read is in flight; swallow its rvalid
module fetch_unit
  import pipe_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 32,
  parameter int unsigned         PC_STEP  = PC_STEP_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_addr,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_instruction,
  output logic                out_valid
);

  fetch_state_e        state_q, state_d;
  logic                started_q;
  logic [31:0]         buffer_q;
  logic [PC_WIDTH-1:0] pc_reg, pc_seq;
  logic                pc_load, emit, buf_load;
  logic [31:0]         emit_data;

  fetch_pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .load_value (branch_addr),
    .incr       (emit),
    .pc         (pc_reg),
    .pc_seq     (pc_seq)
  );

  assign imem_addr = pc_reg;

  // started_q keeps the first cycle after reset release quiet on imem.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_REQ;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (started_q && !branch_taken && imem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (branch_taken) state_d = imem_rvalid ? ST_REQ : ST_KILL;
        else if (imem_rvalid) state_d = freeze ? ST_HOLD : ST_REQ;
      end
      ST_HOLD: begin
        if (branch_taken || !freeze) state_d = ST_REQ;
      end
      ST_KILL: begin
        if (imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    pc_load   = 1'b0;
    emit      = 1'b0;
    buf_load  = 1'b0;
    emit_data = imem_rdata;
    case (state_q)
      ST_REQ: begin
        imem_req = started_q && !branch_taken;
        pc_load  = started_q && branch_taken;
      end
      ST_WAIT: begin
        pc_load  = branch_taken;
        emit     = !branch_taken && imem_rvalid && !freeze;
        buf_load = !branch_taken && imem_rvalid && freeze;
      end
      ST_HOLD: begin
        pc_load   = branch_taken;
        emit      = !branch_taken && !freeze;
        emit_data = buffer_q;
      end
      ST_KILL: begin
        pc_load = branch_taken;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer_q        <= NOP_INSTR;
      out_pc          <= '0;
      out_instruction <= NOP_INSTR;
      out_valid       <= 1'b0;
    end else begin
      out_valid <= emit;
      if (buf_load) buffer_q <= imem_rdata;
      if (emit) begin
        out_pc          <= pc_seq;
        out_instruction <= emit_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance starts at the top of the address space.
module tb_fetch_unit;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, branch_taken, imem_ready, imem_rvalid;
  logic [31:0] branch_addr, imem_rdata;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_pc, out_instruction;
  logic        w_imem_req, w_out_valid;
  logic [31:0] w_imem_addr, w_out_pc, w_out_instruction;

  int errors = 0;
  int checks = 0;
  logic stale_ok = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_pc(out_pc), .out_instruction(out_instruction), .out_valid(out_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_pc(w_out_pc), .out_instruction(w_out_instruction), .out_valid(w_out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // An rvalid is only legal while a read is outstanding.
  always @(negedge clk) begin
    if (rst && imem_rvalid && !stale_ok) begin
      assert (dut.state_q == ST_WAIT || dut.state_q == ST_KILL) else begin
        errors++;
        $error("FAIL protocol rvalid_without_request state=%0d", dut.state_q);
      end
    end
  end

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    cyc(); cyc();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instruction, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);

    rst = 1'b1;
    #1 chk("quiet_after_release", {31'b0, imem_req}, 32'h0);
    cyc();
    chk("seq_req0", {31'b0, imem_req}, 32'h1);
    chk("seq_addr0", imem_addr, 32'h0);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hA0;
    #1 chk("seq_wait_req", {31'b0, imem_req}, 32'h0);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("seq_v0", {31'b0, out_valid}, 32'h1);
    chk("seq_pc0", out_pc, 32'h4);
    chk("seq_ins0", out_instruction, 32'hA0);
    chk("seq_addr1", imem_addr, 32'h4);
    chk("wrap_valid", {31'b0, w_out_valid}, 32'h1);
    chk("wrap_out_pc", w_out_pc, 32'h0);
    chk("wrap_next_addr", w_imem_addr, 32'h0);
    cyc();
    chk("seq_pulse_drop", {31'b0, out_valid}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hA1;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("seq_pc1", out_pc, 32'h8);
    chk("seq_ins1", out_instruction, 32'hA1);
    chk("seq_addr2", imem_addr, 32'h8);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hA2;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("seq_v2", {31'b0, out_valid}, 32'h1);
    chk("seq_pc2", out_pc, 32'hC);
    chk("seq_ins2", out_instruction, 32'hA2);

    // Freeze for three cycles as the data returns from pc=0xC.
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; freeze = 1'b1;
    cyc();
    imem_rvalid = 1'b0;
    #1 chk("frz_v_a", {31'b0, out_valid}, 32'h0);
    cyc();
    chk("frz_v_b", {31'b0, out_valid}, 32'h0);
    chk("frz_no_req", {31'b0, imem_req}, 32'h0);
    cyc();
    freeze = 1'b0;
    #1 chk("frz_v_c", {31'b0, out_valid}, 32'h0);
    cyc();
    chk("frz_v", {31'b0, out_valid}, 32'h1);
    chk("frz_ins", out_instruction, 32'hDEADBEEF);
    chk("frz_pc", out_pc, 32'h10);
    chk("frz_next_addr", imem_addr, 32'h10);

    // Redirect while the read is in flight: its data must be swallowed.
    cyc();
    branch_taken = 1'b1; branch_addr = 32'h100;
    cyc();
    branch_taken = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    #1 chk("kill_req", {31'b0, imem_req}, 32'h0);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("kill_no_emit", {31'b0, out_valid}, 32'h0);
    chk("kill_req_after", {31'b0, imem_req}, 32'h1);
    chk("kill_addr", imem_addr, 32'h100);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("kill_emit_v", {31'b0, out_valid}, 32'h1);
    chk("kill_emit_pc", out_pc, 32'h104);
    chk("kill_emit_ins", out_instruction, 32'h2222_2222);

    // Redirect coinciding with rvalid.
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; branch_taken = 1'b1; branch_addr = 32'h40;
    #1 chk("brv_req", {31'b0, imem_req}, 32'h0);
    cyc();
    imem_rvalid = 1'b0; branch_taken = 1'b0;
    #1;
    chk("brv_no_emit", {31'b0, out_valid}, 32'h0);
    chk("brv_req_back", {31'b0, imem_req}, 32'h1);
    chk("brv_addr", imem_addr, 32'h40);
    // Redirect in REQ suppresses the request in its own cycle.
    branch_taken = 1'b1; branch_addr = 32'h80;
    #1 chk("req_br_req", {31'b0, imem_req}, 32'h0);
    cyc();
    branch_taken = 1'b0; imem_ready = 1'b0;
    #1 chk("req_br_addr", imem_addr, 32'h80);
    cyc();
    chk("stall_req", {31'b0, imem_req}, 32'h1);
    chk("stall_addr", imem_addr, 32'h80);
    imem_ready = 1'b1;
    cyc();
    // Asynchronous reset while in WAIT.
    rst = 1'b0;
    #1;
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_out_instr", out_instruction, 32'h0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    cyc();
    rst = 1'b1; stale_ok = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h9999_9999;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    stale_ok = 1'b0;
    chk("stale_no_emit", {31'b0, out_valid}, 32'h0);
    chk("stale_req", {31'b0, imem_req}, 32'h1);
    chk("stale_addr", imem_addr, 32'h0);
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("post_rst_v", {31'b0, out_valid}, 32'h1);
    chk("post_rst_pc", out_pc, 32'h4);
    chk("post_rst_ins", out_instruction, 32'h5555_5555);

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
